mult_div_unit: RTL

Iterative multiply/divide unit downstream of the register file. It consumes readData1/readData2 as srcA/srcB and produces the architectural HI/LO pair for MULT, MULTU, DIV and DIVU, and accepts MTHI/MTLO writes. Multi-cycle: holds busy while computing so the control path stalls MFHI/MFLO and further mult/div issue.

---
 rtl/mult_div_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle shift-add multiplier / restoring divider producing HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q, neg_q, rem_neg_q, dz_q, busy_q, done_q;
  logic [WIDTH-1:0]   acc_q, q_q, b_q, hi_q, lo_q;
  logic               a_neg, b_neg, ge;
  logic [WIDTH-1:0]   mag_a, mag_b, acc_d, q_d, quo_s, rem_s, hi_d, lo_d;
  logic [WIDTH:0]     msum, rem_sh;
  logic [2*WIDTH-1:0] prod, prod_s;
  // acc_q/q_q form the product (upper/lower) for multiply and remainder/quotient for divide
  always_comb begin
    a_neg  = ~op[0] & srcA[WIDTH-1];
    b_neg  = ~op[0] & srcB[WIDTH-1];
    mag_a  = a_neg ? -srcA : srcA;
    mag_b  = b_neg ? -srcB : srcB;
    msum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {acc_q, q_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, b_q};
    acc_d  = div_q ? (ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0]) : msum[WIDTH:1];
    q_d    = div_q ? {q_q[WIDTH-2:0], ge} : {msum[0], q_q[WIDTH-1:1]};
    prod   = {acc_q, q_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = dz_q ? '1 : (neg_q ? -q_q : q_q);
    rem_s  = rem_neg_q ? -acc_q : acc_q;
    hi_d   = div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    lo_d   = div_q ? quo_s : prod_s[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            div_q     <= op[1];
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= op[1] & (srcB == '0);
            acc_q     <= '0;
            q_q       <= op[1] ? mag_a : mag_b;
            b_q       <= op[1] ? mag_b : mag_a;
          end else begin
            if (mthi) hi_q <= srcA;
            if (mtlo) lo_q <= srcA;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= FINISH;
        end
        FINISH: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
